// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the fetch-stage PC unit and its BTB.
// The BTB types are only used when PC_BTB_EN is defined.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // The tag is kept right-justified in a 30-bit field. Bits above the real tag width stay zero.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [29:0] target;
    } btb_entry_t;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: hazard and EX-stage controls into the PC unit, fetch address out.
// The master modport is the pipeline side. The slave modport is pc_fetch_unit.
interface pc_fetch_unit_if;
    logic        stall_f;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic        btb_wr_e;
    logic [31:0] pc_e;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic        fetch_valid_f;
    logic        pred_taken_f;
    logic        misalign_f;

    modport master (
        output stall_f, pc_src_e, pc_target_e, btb_wr_e, pc_e,
        input  pc_f, pc_plus4_f, fetch_valid_f, pred_taken_f, misalign_f
    );

    modport slave (
        input  stall_f, pc_src_e, pc_target_e, btb_wr_e, pc_e,
        output pc_f, pc_plus4_f, fetch_valid_f, pred_taken_f, misalign_f
    );
endinterface

// File: rtl/pc_fetch_unit_btb.sv
// Direct-mapped branch target buffer. Lookup is combinational and writes happen on the clock edge.
// A write and a lookup of the same entry in one cycle returns the old contents.
module pc_btb
    import pc_fetch_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_lookup_pc,
    output logic        o_hit,
    output logic [31:0] o_target,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_pc,
    input  logic [31:0] i_wr_target
);

    localparam int IDX = clog2(ENTRIES);

    btb_entry_t        r_mem [ENTRIES];
    logic [IDX-1:0]    w_lk_idx;
    logic [IDX-1:0]    w_wr_idx;
    logic [29:0]       w_lk_tag;
    logic [29:0]       w_wr_tag;
    btb_entry_t        w_rd;
    logic              w_unused_low;

    assign w_lk_idx = i_lookup_pc[IDX+1:2];
    assign w_wr_idx = i_wr_pc[IDX+1:2];
    assign w_lk_tag = 30'(i_lookup_pc[31:2] >> IDX);
    assign w_wr_tag = 30'(i_wr_pc[31:2] >> IDX);

    assign w_rd     = r_mem[w_lk_idx];
    assign o_hit    = w_rd.valid && (w_rd.tag == w_lk_tag);
    assign o_target = {w_rd.target, 2'b00};

    assign w_unused_low = &{1'b0, i_lookup_pc[1:0], i_wr_pc[1:0], i_wr_target[1:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[w_wr_idx] <= '{valid: 1'b1, tag: w_wr_tag, target: i_wr_target[31:2]};
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC register with redirect parking across stalls and an optional BTB (PC_BTB_EN).
// Next PC priority: EX redirect > BTB prediction > PC+4.
//
//   state | meaning
//   BOOT  | first cycle after reset release, PC held, fetch not valid
//   RUN   | normal fetch, PC advances unless stalled
//   HOLD  | stalled with a redirect parked in r_pend_tgt
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    pc_fetch_unit_if.slave  fif
);

    localparam logic [1:0] S_BOOT = 2'(BOOT);
    localparam logic [1:0] S_RUN  = 2'(RUN);
    localparam logic [1:0] S_HOLD = 2'(HOLD);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_tgt;
    logic        r_misalign;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pend_nxt;
    logic [31:0] w_redir_raw;
    logic        w_load_redir;
    logic [31:0] w_pc_plus4;
    logic        w_pred_hit;
    logic [31:0] w_pred_tgt;

    assign w_pc_plus4 = r_pc + INSTR_BYTES;

`ifdef PC_BTB_EN
    pc_btb #(
        .ENTRIES     (BTB_ENTRIES)
    ) u_btb (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_lookup_pc (r_pc),
        .o_hit       (w_pred_hit),
        .o_target    (w_pred_tgt),
        .i_wr_en     (fif.btb_wr_e),
        .i_wr_pc     (fif.pc_e),
        .i_wr_target (fif.pc_target_e)
    );
`else
    logic w_unused_btb;
    assign w_pred_hit   = 1'b0;
    assign w_pred_tgt   = '0;
    assign w_unused_btb = &{1'b0, fif.btb_wr_e, fif.pc_e, (BTB_ENTRIES > 0)};
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_pend_nxt   = r_pend_tgt;
        w_redir_raw  = fif.pc_target_e;
        w_load_redir = 1'b0;
        case (r_state)
            S_BOOT: w_state_nxt = S_RUN;
            S_RUN: begin
                if (!fif.stall_f) begin
                    if (fif.pc_src_e) w_load_redir = 1'b1;
                    else if (w_pred_hit) w_pc_nxt = w_pred_tgt;
                    else w_pc_nxt = w_pc_plus4;
                end else if (fif.pc_src_e) begin
                    w_pend_nxt  = fif.pc_target_e;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (fif.stall_f) begin
                    if (fif.pc_src_e) w_pend_nxt = fif.pc_target_e;
                end else begin
                    // A redirect arriving on the release cycle is younger than the parked one.
                    w_load_redir = 1'b1;
                    w_redir_raw  = fif.pc_src_e ? fif.pc_target_e : r_pend_tgt;
                    w_pend_nxt   = '0;
                    w_state_nxt  = S_RUN;
                end
            end
            default: w_state_nxt = S_BOOT;
        endcase
        if (w_load_redir) w_pc_nxt = {w_redir_raw[31:2], 2'b00};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_VEC;
            r_pend_tgt <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend_tgt <= w_pend_nxt;
            r_misalign <= w_load_redir && (w_redir_raw[1:0] != 2'b00);
        end
    end

    assign fif.pc_f          = r_pc;
    assign fif.pc_plus4_f    = w_pc_plus4;
    assign fif.fetch_valid_f = (r_state != S_BOOT);
    assign fif.pred_taken_f  = w_pred_hit;
    assign fif.misalign_f    = r_misalign;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios, then randomized traffic checked against a behavioural model.
// The BTB scenarios are only built when PC_BTB_EN is defined.
module tb_pc_fetch_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam int          NE = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_unit_if bus();

    pc_fetch_unit #(
        .RESET_VEC   (RV),
        .BTB_ENTRIES (NE)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .fif     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: a boot flag, an optional parked target, and a BTB keyed by full word address.
    bit          m_boot;
    logic [31:0] m_pc;
    bit          m_pend_v;
    logic [31:0] m_pend;
    bit          m_mis;
    bit          mb_v    [NE];
    logic [29:0] mb_word [NE];
    logic [31:0] mb_tgt  [NE];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic int bidx(input logic [31:0] pc);
        return int'((pc >> 2) % NE);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
`ifdef PC_BTB_EN
        return mb_v[bidx(pc)] && (mb_word[bidx(pc)] == pc[31:2]);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_boot   = 1'b1;
        m_pc     = RV;
        m_pend_v = 1'b0;
        m_pend   = '0;
        m_mis    = 1'b0;
        for (int i = 0; i < NE; i++) mb_v[i] = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit src, input logic [31:0] tgt,
                              input bit wr, input logic [31:0] pce);
        logic [31:0] nxt;
        logic [31:0] raw;
        bit          load;
        nxt  = m_pc;
        raw  = tgt;
        load = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (!m_pend_v) begin
            if (!s) begin
                if (src) load = 1'b1;
                else if (m_hit(m_pc)) nxt = {mb_tgt[bidx(m_pc)][31:2], 2'b00};
                else nxt = m_pc + 32'd4;
            end else if (src) begin
                m_pend_v = 1'b1;
                m_pend   = tgt;
            end
        end else begin
            if (s) begin
                if (src) m_pend = tgt;
            end else begin
                load     = 1'b1;
                raw      = src ? tgt : m_pend;
                m_pend_v = 1'b0;
            end
        end
        m_mis = load && (raw[1:0] != 2'b00);
        m_pc  = load ? {raw[31:2], 2'b00} : nxt;
        if (wr) begin
            mb_v[bidx(pce)]    = 1'b1;
            mb_word[bidx(pce)] = pce[31:2];
            mb_tgt[bidx(pce)]  = tgt;
        end
    endtask

    task automatic check_all();
        chk("pcf",      bus.pc_f,                    m_pc);
        chk("pcplus4f", bus.pc_plus4_f,              m_pc + 32'd4);
        chk("fvalid",   32'(bus.fetch_valid_f),      32'(!m_boot));
        chk("predtkn",  32'(bus.pred_taken_f),       32'(m_hit(m_pc)));
        chk("misalign", 32'(bus.misalign_f),         32'(m_mis));
    endtask

    task automatic drive_idle();
        bus.stall_f     = 1'b0;
        bus.pc_src_e    = 1'b0;
        bus.pc_target_e = '0;
        bus.btb_wr_e    = 1'b0;
        bus.pc_e        = '0;
    endtask

    task automatic cyc(input bit s, input bit src, input logic [31:0] tgt,
                       input bit wr, input logic [31:0] pce);
        bus.stall_f     = s;
        bus.pc_src_e    = src;
        bus.pc_target_e = tgt;
        bus.btb_wr_e    = wr;
        bus.pc_e        = pce;
        @(posedge clk);
        model_step(s, src, tgt, wr, pce);
        @(negedge clk);
        check_all();
    endtask

    // Reset is asserted asynchronously in the middle of the low phase.
    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        drive_idle();
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        if ($urandom_range(0, 3) != 0) a = 32'($urandom_range(0, 63)) << 2;
        else a = $urandom;
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1);
    end

    initial begin
        drive_idle();
        do_reset();
        chk("t1_boot_pc", bus.pc_f, 32'h0);
        chk("t1_boot_valid", 32'(bus.fetch_valid_f), 32'h0);

        cyc(0, 0, 0, 0, 0);
        chk("t1_run_pc0", bus.pc_f, 32'h0);
        chk("t1_run_valid", 32'(bus.fetch_valid_f), 32'h1);
        cyc(0, 0, 0, 0, 0);
        chk("t1_pc4", bus.pc_f, 32'h4);
        cyc(0, 0, 0, 0, 0);
        chk("t1_pc8", bus.pc_f, 32'h8);

        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t2_pc10", bus.pc_f, 32'h10);
        cyc(0, 1, 32'h100, 0, 0);
        chk("t2_redir_pc", bus.pc_f, 32'h100);
        chk("t2_redir_p4", bus.pc_plus4_f, 32'h104);
        chk("t2_no_mis", 32'(bus.misalign_f), 32'h0);

        cyc(0, 1, 32'h20, 0, 0);
        cyc(1, 1, 32'h80, 0, 0);
        chk("t3_hold0", bus.pc_f, 32'h20);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0);
            chk("t3_hold", bus.pc_f, 32'h20);
        end
        cyc(0, 0, 0, 0, 0);
        chk("t3_release", bus.pc_f, 32'h80);

        cyc(0, 1, 32'h203, 0, 0);
        chk("t4_pc", bus.pc_f, 32'h200);
        chk("t4_mis_on", 32'(bus.misalign_f), 32'h1);
        cyc(0, 0, 0, 0, 0);
        chk("t4_mis_off", 32'(bus.misalign_f), 32'h0);

        cyc(0, 1, 32'hFFFF_FFFC, 0, 0);
        chk("t5_p4_wrap", bus.pc_plus4_f, 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk("t5_pc_wrap", bus.pc_f, 32'h0);

`ifdef PC_BTB_EN
        cyc(0, 0, 32'h400, 1, 32'h40);
        cyc(0, 1, 32'h40, 0, 0);
        chk("t6_pred_hit", 32'(bus.pred_taken_f), 32'h1);
        cyc(0, 0, 0, 0, 0);
        chk("t6_pred_pc", bus.pc_f, 32'h400);
        cyc(1, 1, 32'h300, 0, 0);
        do_reset();
        chk("t6_rst_pc", bus.pc_f, RV);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 32'h40, 0, 0);
        chk("t6_btb_miss", 32'(bus.pred_taken_f), 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk("t6_miss_pc", bus.pc_f, 32'h44);
`endif

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                cyc(($urandom_range(0, 9) < 3),
                    ($urandom_range(0, 9) < 2),
                    rnd_addr(),
                    ($urandom_range(0, 3) == 0),
                    rnd_addr());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
